bsw_seq_loader: RTL and testbench

Upstream feeder for the banded Smith-Waterman accelerator (`bsw_acc`). It accepts a byte stream of ASCII nucleotides and packs the first `N_BASES` into the reference word and the next `N_BASES` into the query word. It then fires the accelerator's `start`, waits for `ready` under a timeout, and presents the aligned pair on a valid/ready result port. One alignment job is in flight at a time.

---
 rtl/bsw_seq_loader_if.sv | 35 +++
 rtl/bsw_seq_loader.sv | 159 +++++++++++++++
 tb/tb_bsw_seq_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsw_seq_loader_if.sv
// Signal bundle between the sequence loader, its byte source, the
// banded Smith-Waterman accelerator and the result consumer.
interface bsw_seq_loader_if #(
  parameter int N_BASES = 12,
  parameter int RES_W   = 30
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [2*N_BASES-1:0] acc_R;
  logic [2*N_BASES-1:0] acc_Q;
  logic                 acc_start;
  logic                 acc_ready;
  logic [RES_W-1:0]     acc_R_aligned;
  logic [RES_W-1:0]     acc_Q_aligned;
  logic [RES_W-1:0]     res_R;
  logic [RES_W-1:0]     res_Q;
  logic                 res_timeout;
  logic                 res_valid;
  logic                 res_ready;
  logic                 err_bad_base;
  logic                 busy;

  modport slave (
    input  in_data, in_valid, acc_ready, acc_R_aligned, acc_Q_aligned, res_ready,
    output in_ready, acc_R, acc_Q, acc_start, res_R, res_Q, res_timeout,
           res_valid, err_bad_base, busy
  );

  modport master (
    output in_data, in_valid, acc_ready, acc_R_aligned, acc_Q_aligned, res_ready,
    input  in_ready, acc_R, acc_Q, acc_start, res_R, res_Q, res_timeout,
           res_valid, err_bad_base, busy
  );
endinterface

// File: rtl/bsw_seq_loader.sv
// Packs an ASCII nucleotide stream into reference/query words, runs one
// accelerator job at a time under a timeout and holds the aligned result.
module bsw_seq_loader #(
  parameter int N_BASES = 12,
  parameter int RES_W   = 30,
  parameter int TIMEOUT = 127
) (
  input logic            clk,
  input logic            reset,
  bsw_seq_loader_if.slave bus
);
  localparam int W     = 2 * N_BASES;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [4:0]       LAST_IDX = 5'(W - 1);
  localparam logic [4:0]       R_LIM    = 5'(N_BASES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_START = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Returns {legal, code}; case-insensitive A=0, T=1, G=2, C=3.
  function automatic logic [2:0] encode_base(input logic [7:0] ch);
    logic [2:0] r;
    case (ch)
      8'h41, 8'h61: r = 3'b100;
      8'h54, 8'h74: r = 3'b101;
      8'h47, 8'h67: r = 3'b110;
      8'h43, 8'h63: r = 3'b111;
      default:      r = 3'b000;
    endcase
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [4:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     r_shadow_r, q_shadow_r, q_next_s;
  logic [W-1:0]     acc_r_r, acc_q_r;
  logic [RES_W-1:0] res_r_r, res_q_r;
  logic             res_timeout_r, err_bad_base_r;
  logic [2:0]       enc_s;
  logic             base_ok_s;
  logic [1:0]       code_s;
  logic             in_ready_s, acc_start_s, res_valid_s, busy_s;

  assign enc_s     = encode_base(bus.in_data);
  assign base_ok_s = enc_s[2];
  assign code_s    = enc_s[1:0];
  // Shifting in keeps the first base of each sequence in the MSBs.
  assign q_next_s  = {q_shadow_r[W-3:0], code_s};

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    acc_start_s = 1'b0;
    res_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      ST_LOAD: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
        if (bus.in_valid && base_ok_s && (idx_r == LAST_IDX)) state_nxt_s = ST_START;
        else                                                  state_nxt_s = ST_LOAD;
      end
      ST_START: begin
        acc_start_s = 1'b1;
        state_nxt_s = ST_GUARD;
      end
      ST_GUARD: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.acc_ready || (cnt_r == TO_LAST)) state_nxt_s = ST_OUT;
        else                                     state_nxt_s = ST_WAIT;
      end
      ST_OUT: begin
        res_valid_s = 1'b1;
        if (bus.res_ready) state_nxt_s = ST_LOAD;
        else               state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_LOAD;
    else       state_r <= state_nxt_s;
  end

  // Packing, operand launch, timeout counting and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r          <= 5'd0;
      cnt_r          <= {CNT_W{1'b0}};
      r_shadow_r     <= {W{1'b0}};
      q_shadow_r     <= {W{1'b0}};
      acc_r_r        <= {W{1'b0}};
      acc_q_r        <= {W{1'b0}};
      res_r_r        <= {RES_W{1'b0}};
      res_q_r        <= {RES_W{1'b0}};
      res_timeout_r  <= 1'b0;
      err_bad_base_r <= 1'b0;
    end else begin
      err_bad_base_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (bus.in_valid && !base_ok_s) begin
            idx_r          <= 5'd0;
            err_bad_base_r <= 1'b1;
          end else if (bus.in_valid) begin
            if (idx_r < R_LIM) r_shadow_r <= {r_shadow_r[W-3:0], code_s};
            else               q_shadow_r <= q_next_s;
            if (idx_r == LAST_IDX) begin
              acc_r_r <= r_shadow_r;
              acc_q_r <= q_next_s;
              idx_r   <= 5'd0;
            end else begin
              idx_r <= idx_r + 5'd1;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_GUARD: cnt_r <= {CNT_W{1'b0}};
        ST_WAIT: begin
          if (bus.acc_ready) begin
            res_r_r       <= bus.acc_R_aligned;
            res_q_r       <= bus.acc_Q_aligned;
            res_timeout_r <= 1'b0;
          end else if (cnt_r == TO_LAST) begin
            res_r_r       <= {RES_W{1'b0}};
            res_q_r       <= {RES_W{1'b0}};
            res_timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.acc_start    = acc_start_s;
  assign bus.res_valid    = res_valid_s;
  assign bus.busy         = busy_s;
  assign bus.acc_R        = acc_r_r;
  assign bus.acc_Q        = acc_q_r;
  assign bus.res_R        = res_r_r;
  assign bus.res_Q        = res_q_r;
  assign bus.res_timeout  = res_timeout_r;
  assign bus.err_bad_base = err_bad_base_r;
endmodule

// File: tb/tb_bsw_seq_loader.sv
// Scenario-driven bench for bsw_seq_loader: operand and result scoreboards
// are filled by the stimulus tasks and drained by negedge monitors.
module tb_bsw_seq_loader;
  localparam int N  = 12;
  localparam int RW = 30;
  localparam int TO = 127;

  typedef struct packed { logic [2*N-1:0] r; logic [2*N-1:0] q; } acc_exp_t;
  typedef struct packed { logic [RW-1:0] r; logic [RW-1:0] q; logic to; } res_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsw_seq_loader_if #(.N_BASES(N), .RES_W(RW)) bus ();
  bsw_seq_loader #(.N_BASES(N), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  acc_exp_t acc_q[$];
  res_exp_t res_q[$];
  acc_exp_t acc_e;
  res_exp_t res_e;
  int  tests = 0;
  int  failed = 0;
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;

  // Operand scoreboard: each rising acc_start consumes one expected pair.
  always @(negedge clk) begin
    if (bus.acc_start === 1'b1) begin
      tests++;
      if (prev_start) begin
        failed++; $display("FAIL start_width: acc_start high two cycles, required one");
      end else if (acc_q.size() == 0) begin
        failed++; $display("FAIL start_unexpected: acc_start=1 with no job pending, required 0");
      end else begin
        acc_e = acc_q.pop_front();
        if (bus.acc_R !== acc_e.r || bus.acc_Q !== acc_e.q) begin
          failed++;
          $display("FAIL acc_operands: acc_R=%h acc_Q=%h, required %h %h",
                   bus.acc_R, bus.acc_Q, acc_e.r, acc_e.q);
        end
      end
    end
    prev_start = (bus.acc_start === 1'b1);
  end

  // Result scoreboard: each rising res_valid consumes one expected result.
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1 && !prev_valid) begin
      tests++;
      if (res_q.size() == 0) begin
        failed++; $display("FAIL res_unexpected: res_valid=1 with no result pending, required 0");
      end else begin
        res_e = res_q.pop_front();
        if (bus.res_R !== res_e.r || bus.res_Q !== res_e.q || bus.res_timeout !== res_e.to) begin
          failed++;
          $display("FAIL res_data: res_R=%h res_Q=%h to=%b, required %h %h %b",
                   bus.res_R, bus.res_Q, bus.res_timeout, res_e.r, res_e.q, res_e.to);
        end
      end
    end
    prev_valid = (bus.res_valid === 1'b1);
  end

  function automatic logic [2*N-1:0] pack(input string s);
    logic [2*N-1:0] v = '0;
    logic [1:0] c;
    for (int k = 0; k < N; k++) begin
      case (s[k])
        8'h41, 8'h61: c = 2'd0;
        8'h54, 8'h74: c = 2'd1;
        8'h47, 8'h67: c = 2'd2;
        default:      c = 2'd3;
      endcase
      v[2*N-1-2*k -: 2] = c;
    end
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (bus.in_ready !== 1'b1) begin
      tests++; failed++; $display("FAIL in_ready_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Runs one job; lat<0 leaves acc_ready low for a timeout. Returns at the
  // first negedge with res_valid expected high.
  task automatic do_job(input string s, input logic [2*N-1:0] er, input logic [2*N-1:0] eq,
                        input int lat, input logic [RW-1:0] ar, input logic [RW-1:0] aq,
                        input bit stale);
    bit early = 1'b0;
    acc_q.push_back('{er, eq});
    if (stale) begin
      bus.acc_ready = 1'b1; bus.acc_R_aligned = 30'h3FFFFFFF; bus.acc_Q_aligned = 30'h2AAAAAAA;
    end
    load_str(s);
    @(negedge clk);
    tests++;
    if (bus.acc_start !== 1'b1) begin
      failed++; $display("FAIL start_timing: acc_start=%b one cycle after last byte, required 1", bus.acc_start);
    end
    @(negedge clk);
    tests++;
    if (bus.acc_start !== 1'b0 || bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
      failed++; $display("FAIL guard_cycle: start=%b busy=%b valid=%b, required 0 1 0",
                         bus.acc_start, bus.busy, bus.res_valid);
    end
    if (lat < 0) begin
      bus.acc_ready = 1'b0;
      res_q.push_back('{{RW{1'b0}}, {RW{1'b0}}, 1'b1});
      for (int m = 1; m < TO + 1; m++) begin
        @(negedge clk);
        if (bus.res_valid !== 1'b0) early = 1'b1;
      end
      tests++;
      if (early) begin failed++; $display("FAIL timeout_early: res_valid=1 before %0d cycles, required 0", TO); end
      @(negedge clk);
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_timeout !== 1'b1 || bus.res_R !== 30'h0 || bus.res_Q !== 30'h0) begin
        failed++; $display("FAIL timeout_result: valid=%b to=%b R=%h Q=%h, required 1 1 0 0",
                           bus.res_valid, bus.res_timeout, bus.res_R, bus.res_Q);
      end
    end else begin
      for (int i = 1; i <= lat; i++) @(negedge clk);
      bus.acc_ready = 1'b1; bus.acc_R_aligned = ar; bus.acc_Q_aligned = aq;
      res_q.push_back('{ar, aq, 1'b0});
      @(negedge clk);
      bus.acc_ready = 1'b0;
      tests++;
      if (bus.res_valid !== 1'b1) begin
        failed++; $display("FAIL ready_capture: res_valid=%b after acc_ready, required 1", bus.res_valid);
      end
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL consume: res_valid=%b in_ready=%b, required 0 1", bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.in_ready, bus.busy, bus.acc_start, bus.res_valid, bus.res_timeout, bus.err_bad_base,
         bus.acc_R, bus.acc_Q, bus.res_R, bus.res_Q} !== {1'b1, 5'b0, 48'h0, 60'h0}) begin
      failed++; $display("FAIL reset_values: rdy=%b busy=%b accR=%h resR=%h, required 1 0 0 0",
                         bus.in_ready, bus.busy, bus.acc_R, bus.res_R);
    end
  endtask

  task automatic test_basic();
    bus.res_ready = 1'b0;
    do_job("TGCTATAACAGATGATAATGCAGA", 24'h6d10c8, 24'h6106c8, 38, 30'h0ABCDEF1, 30'h01234567, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_R !== 30'h0ABCDEF1 ||
          bus.res_Q !== 30'h01234567 || bus.res_timeout !== 1'b0) begin
        failed++; $display("FAIL backpressure_hold: valid=%b rdy=%b R=%h, required 1 0 0abcdef1",
                           bus.res_valid, bus.in_ready, bus.res_R);
      end
    end
    consume();
  endtask

  task automatic test_lowercase();
    do_job("tgctataacagatgataatgcaga", 24'h6d10c8, 24'h6106c8, 5, 30'h15555555, 30'h0000FFFF, 1'b0);
    consume();
  endtask

  task automatic test_bad_base();
    load_str("TGCTA");
    send_byte(8'h4E);
    @(negedge clk);
    tests++;
    if (bus.err_bad_base !== 1'b1) begin failed++; $display("FAIL bad_base_pulse: err=%b, required 1", bus.err_bad_base); end
    @(negedge clk);
    tests++;
    if (bus.err_bad_base !== 1'b0) begin failed++; $display("FAIL bad_base_width: err=%b, required 0", bus.err_bad_base); end
    do_job("CCAAGGTTACGTGATTACAGGCAT", pack("CCAAGGTTACGT"), pack("GATTACAGGCAT"), 3,
           30'h00C0FFEE, 30'h0BADF00D, 1'b0);
    consume();
  endtask

  task automatic test_timeout();
    do_job("GGGGCCCCAAAATTTTACGTACGT", pack("GGGGCCCCAAAA"), pack("TTTTACGTACGT"), -1,
           30'h0, 30'h0, 1'b0);
    consume();
  endtask

  task automatic test_stale_ready();
    do_job("ACGTACGTACGTTGCATGCATGCA", pack("ACGTACGTACGT"), pack("TGCATGCATGCA"), 1,
           30'h11111111, 30'h22222222, 1'b1);
    consume();
  endtask

  task automatic test_back_to_back();
    do_job("AAAAAAAAAAAACCCCCCCCCCCC", pack("AAAAAAAAAAAA"), pack("CCCCCCCCCCCC"), 2,
           30'h00000001, 30'h00000002, 1'b0);
    consume();
    do_job("TTTTTTTTTTTTGGGGGGGGGGGG", pack("TTTTTTTTTTTT"), pack("GGGGGGGGGGGG"), 7,
           30'h3FFFFFFE, 30'h20000000, 1'b0);
    consume();
  endtask

  task automatic test_reset_mid();
    bit leak = 1'b0;
    load_str("ACGTTGCAACGTTGCAA");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tests++;
    if ({bus.in_ready, bus.busy, bus.acc_start, bus.res_valid, bus.res_timeout, bus.err_bad_base,
         bus.acc_R, bus.acc_Q, bus.res_R, bus.res_Q} !== {1'b1, 5'b0, 48'h0, 60'h0}) begin
      failed++; $display("FAIL reset_mid_load: rdy=%b busy=%b accR=%h resR=%h, required 1 0 0 0",
                         bus.in_ready, bus.busy, bus.acc_R, bus.res_R);
    end
    do_job("GATCGATCGATCCTAGCTAGCTAG", pack("GATCGATCGATC"), pack("CTAGCTAGCTAG"), 4,
           30'h0FEDCBA9, 30'h01020304, 1'b0);
    consume();
    // Reset while waiting on the accelerator, then a late ready in LOAD.
    acc_q.push_back('{pack("CAGTCAGTCAGT"), pack("TTGGCCAATTGG")});
    load_str("CAGTCAGTCAGTTTGGCCAATTGG");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    bus.acc_ready = 1'b1; bus.acc_R_aligned = 30'h3ABCDEF0; bus.acc_Q_aligned = 30'h3ABCDEF0;
    @(negedge clk); bus.acc_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) leak = 1'b1;
    end
    tests++;
    if (leak) begin failed++; $display("FAIL reset_wait_drop: res_valid or busy rose after reset, required 0"); end
    // Reset during the start pulse.
    acc_q.push_back('{pack("TTTTCCCCGGGG"), pack("AAAATTTTCCCC")});
    load_str("TTTTCCCCGGGGAAAATTTTCCCC");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tests++;
    if (bus.acc_start !== 1'b0 || bus.acc_R !== 24'h0 || bus.busy !== 1'b0) begin
      failed++; $display("FAIL reset_in_start: start=%b accR=%h busy=%b, required 0 0 0",
                         bus.acc_start, bus.acc_R, bus.busy);
    end
    do_job("CGCGCGCGCGCGATATATATATAT", pack("CGCGCGCGCGCG"), pack("ATATATATATAT"), 10,
           30'h2468ACE0, 30'h13579BDF, 1'b0);
    consume();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.acc_ready = 1'b0;
    bus.acc_R_aligned = 30'h0; bus.acc_Q_aligned = 30'h0; bus.res_ready = 1'b1;
    test_reset();
    test_basic();
    test_lowercase();
    test_bad_base();
    test_timeout();
    test_stale_ready();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (acc_q.size() != 0 || res_q.size() != 0) begin
      failed++; $display("FAIL scoreboard_drain: %0d operand / %0d result entries left, required 0 0",
                         acc_q.size(), res_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
